// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
// Multi-cycle control unit for the RISC-V datapath. Owns the program counter
// (a word index) and the 4-bit state code. The unit steps through fetch,
// decode, execute, memory and write-back. It decodes the fetched instruction
// word and drives the datapath strobes combinationally from state and opcode.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   instrucao   instruction word from fetch memory (valid DECODE..retire)
//   zero        ALU zero flag, used in BRANCH
//   imm         sign-extended byte offset from the immediate generator
//   estado      current state code
//   PC          word index of the current instruction
//   reg_write   register-file write enable (WB)
//   mem_read    data-memory read enable (MEM, LOAD)
//   mem_write   data-memory write enable (MEM, STORE)
//   alu_src     ALU operand B select: 0 = rs2, 1 = imm
//   mem_to_reg  write-back source select: 0 = ALU, 1 = memory
//   alu_op      ALU class: 00 add, 01 sub, 10 R funct, 11 I funct
//   halted      high while in HALT
//   illegal     sticky flag: execution stopped on an unknown opcode
//
// state  | code | meaning
// BUSCA  | 0000 | fetch memory loads instrucao from PC on this edge
// DECODE | 0001 | opcode classified, next state chosen
// EXEC   | 0010 | ALU operation for R / I-ALU / address for LOAD, STORE
// MEM    | 0011 | data-memory access; STORE retires here
// WB     | 0100 | register write-back; R, I-ALU, LOAD retire here
// BRANCH | 0101 | beq compare (ALU sub); retires with taken/not-taken PC
// HALT   | 1110 | execution ended; held until reset
// -----------------------------------------------------------------------------
module unidade_controle #(
  parameter int unsigned NUM_INSTR = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrucao,
  input  logic        zero,
  input  logic [31:0] imm,
  output logic [3:0]  estado,
  output logic [31:0] PC,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] S_BUSCA  = 4'b0000;
  localparam logic [3:0] S_DECODE = 4'b0001;
  localparam logic [3:0] S_EXEC   = 4'b0010;
  localparam logic [3:0] S_MEM    = 4'b0011;
  localparam logic [3:0] S_WB     = 4'b0100;
  localparam logic [3:0] S_BRANCH = 4'b0101;
  localparam logic [3:0] S_HALT   = 4'b1110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RFN  = 2'b10;
  localparam logic [1:0] ALU_IFN  = 2'b11;

  logic [3:0]  r_estado;
  logic [31:0] r_pc;
  logic        r_illegal;

  logic [3:0]  w_estado_nxt;
  logic        w_set_illegal;
  logic        w_retire;
  logic        w_pc_load;

  logic [6:0]  w_opcode;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;

  logic [31:0] w_imm_words;
  logic [31:0] w_next_pc;
  logic        w_next_oob;

  // Only the opcode field and the word-aligned part of imm matter here.
  logic        w_unused_bits;
  assign w_unused_bits = ^{instrucao[31:7], imm[1:0]};

  assign w_opcode    = instrucao[6:0];
  assign w_is_r      = (w_opcode == OP_R);
  assign w_is_i      = (w_opcode == OP_I);
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_branch = (w_opcode == OP_BRANCH);

  // imm is a byte offset; PC counts words, so shift arithmetically by 2.
  assign w_imm_words = {{2{imm[31]}}, imm[31:2]};

  assign w_next_pc = (r_estado == S_BRANCH && zero) ? (r_pc + w_imm_words)
                                                    : (r_pc + 32'd1);

  // Unsigned compare: a negative wrap lands far above NUM_INSTR and halts.
  assign w_next_oob = (w_next_pc >= NUM_INSTR);

  assign w_retire = (r_estado == S_WB) ||
                    (r_estado == S_BRANCH) ||
                    (r_estado == S_MEM && w_is_store);

  assign w_pc_load = w_retire && !w_next_oob;

  always_comb begin
    w_estado_nxt  = r_estado;
    w_set_illegal = 1'b0;
    case (r_estado)
      S_BUSCA: w_estado_nxt = S_DECODE;
      S_DECODE: begin
        if (w_is_r || w_is_i || w_is_load || w_is_store) begin
          w_estado_nxt = S_EXEC;
        end else if (w_is_branch) begin
          w_estado_nxt = S_BRANCH;
        end else begin
          w_estado_nxt  = S_HALT;
          w_set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_estado_nxt = S_MEM;
        end else if (w_is_r || w_is_i) begin
          w_estado_nxt = S_WB;
        end else begin
          // instrucao changed under us; nothing sane to do but stop
          w_estado_nxt = S_HALT;
        end
      end
      S_MEM: begin
        if (w_is_load) begin
          w_estado_nxt = S_WB;
        end else if (w_is_store) begin
          w_estado_nxt = w_next_oob ? S_HALT : S_BUSCA;
        end else begin
          w_estado_nxt = S_HALT;
        end
      end
      S_WB, S_BRANCH: w_estado_nxt = w_next_oob ? S_HALT : S_BUSCA;
      S_HALT:         w_estado_nxt = S_HALT;
      default:        w_estado_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= S_BUSCA;
      r_pc      <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      if (w_pc_load) begin
        r_pc <= w_next_pc;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_ADD;
    case (r_estado)
      S_EXEC, S_MEM, S_WB: begin
        alu_src = w_is_i || w_is_load || w_is_store;
        if (w_is_r) begin
          alu_op = ALU_RFN;
        end else if (w_is_i) begin
          alu_op = ALU_IFN;
        end else begin
          alu_op = ALU_ADD;
        end
        if (r_estado == S_MEM) begin
          mem_read  = w_is_load;
          mem_write = w_is_store;
        end
        if (r_estado == S_WB) begin
          reg_write  = 1'b1;
          mem_to_reg = w_is_load;
        end
      end
      S_BRANCH: begin
        alu_op  = ALU_SUB;
        alu_src = 1'b0;
      end
      default: ;
    endcase
  end

  assign estado  = r_estado;
  assign PC      = r_pc;
  assign halted  = (r_estado == S_HALT);
  assign illegal = r_illegal;

endmodule
